// File: rtl/sub16_serial_pkg.sv
// Shared constants, FSM encoding and flag bundle for the bit-serial subtractor.
package sub16_serial_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CNT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic borrow;
    logic overflow;
    logic negative;
    logic zero;
  } flags_t;

  // Signed overflow of a - b: operands of opposite sign and the result sign differs from a.
  function automatic logic sub_overflow(input logic a_msb, input logic b_msb, input logic r_msb);
    return (a_msb != b_msb) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/sub16_serial_if.sv
// Start/busy/done request bus of the serial subtractor; master issues operands, slave returns result and flags.
interface sub16_serial_if
  import sub16_serial_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             borrow;
  logic             overflow;
  logic             negative;
  logic             zero;

  modport master (
    output start, a, b,
    input  busy, done, result, borrow, overflow, negative, zero
  );

  modport slave (
    input  start, a, b,
    output busy, done, result, borrow, overflow, negative, zero
  );
endinterface

// File: rtl/sub16_serial_full_subtractor.sv
// One-bit full subtractor cell (d = x - y - bin) built from gate primitives; purely combinational.
module sub16_serial_full_subtractor (
  input  wire x_i,
  input  wire y_i,
  input  wire bin_i,
  output wire d_o,
  output wire bout_o
);
  wire x_xor_y;
  wire x_n;
  wire xnor_xy;
  wire brw_gen;
  wire brw_prop;

  xor g_x0 (x_xor_y, x_i, y_i);
  xor g_x1 (d_o, x_xor_y, bin_i);
  not g_n0 (x_n, x_i);
  and g_a0 (brw_gen, x_n, y_i);
  not g_n1 (xnor_xy, x_xor_y);
  and g_a1 (brw_prop, xnor_xy, bin_i);
  or  g_o0 (bout_o, brw_gen, brw_prop);
endmodule

// File: rtl/sub16_serial.sv
// Bit-serial a - b, LSB first; done pulses 16 clocks after the accepted start.
// start is only accepted in IDLE or DONE; requests while busy are dropped.
module sub16_serial
  import sub16_serial_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic           clk,
  input  logic           reset,
  sub16_serial_if.slave  bus
);

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_d;
  logic [WIDTH-1:0] result_q;
  logic [CNT_W-1:0] cnt_q;
  logic             brw_q;
  logic             brw_d;
  logic             diff_bit;
  logic             a_msb_q;
  logic             b_msb_q;
  logic             last_bit;
  logic             busy_q;
  logic             done_q;
  flags_t           flags_q;
  flags_t           flags_d;

  sub16_serial_full_subtractor u_fsub (
    .x_i    (a_q[0]),
    .y_i    (b_q[0]),
    .bin_i  (brw_q),
    .d_o    (diff_bit),
    .bout_o (brw_d)
  );

  // Each new difference bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts.
  always_comb begin
    res_d            = {diff_bit, res_q[WIDTH-1:1]};
    last_bit         = (cnt_q == CNT_W'(WIDTH - 1));
    flags_d.borrow   = brw_d;
    flags_d.overflow = sub_overflow(a_msb_q, b_msb_q, res_d[WIDTH-1]);
    flags_d.negative = res_d[WIDTH-1];
    flags_d.zero     = (res_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      brw_q    <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      flags_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            a_msb_q <= bus.a[WIDTH-1];
            b_msb_q <= bus.b[WIDTH-1];
            brw_q   <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          res_q <= res_d;
          brw_q <= brw_d;
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_bit) begin
            state_q  <= ST_DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= res_d;
            flags_q  <= flags_d;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.borrow   = flags_q.borrow;
  assign bus.overflow = flags_q.overflow;
  assign bus.negative = flags_q.negative;
  assign bus.zero     = flags_q.zero;

endmodule

// File: tb/tb_sub16_serial.sv
// Directed bench for sub16_serial: arithmetic reference model checked every cycle plus literal expectations.
module tb_sub16_serial;

  logic clk;
  logic reset;
  logic chk_on;
  int   n_vec;
  int   n_err;

  sub16_serial_if bus ();

  sub16_serial dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: an accepted request yields a - b exactly 16 edges later.
  logic        m_busy, m_done, m_brw, m_ovf, m_neg, m_zero;
  logic [15:0] m_res, m_a, m_b;
  int          m_left;
  wire  [15:0] m_diff = m_a - m_b;

  always @(posedge clk) begin
    if (reset) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_res <= 16'h0; m_brw <= 1'b0;
      m_ovf  <= 1'b0; m_neg  <= 1'b0; m_zero <= 1'b0; m_left <= 0;
    end else if (m_busy) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_res  <= m_diff;
        m_brw  <= (m_a < m_b);
        m_ovf  <= (m_a[15] != m_b[15]) && (m_diff[15] != m_a[15]);
        m_neg  <= m_diff[15];
        m_zero <= (m_diff == 16'h0);
      end
    end else begin
      m_done <= 1'b0;
      if (bus.start) begin
        m_busy <= 1'b1;
        m_left <= 16;
        m_a    <= bus.a;
        m_b    <= bus.b;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("cyc_busy",     32'(bus.busy),     32'(m_busy));
      chk("cyc_done",     32'(bus.done),     32'(m_done));
      chk("cyc_result",   32'(bus.result),   32'(m_res));
      chk("cyc_borrow",   32'(bus.borrow),   32'(m_brw));
      chk("cyc_overflow", 32'(bus.overflow), 32'(m_ovf));
      chk("cyc_negative", 32'(bus.negative), 32'(m_neg));
      chk("cyc_zero",     32'(bus.zero),     32'(m_zero));
    end
  end

  task automatic start_op(input logic [15:0] ai, input logic [15:0] bi);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.a = ai; bus.b = bi;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.a = ~ai; bus.b = ai ^ 16'h5A5A;
  endtask

  task automatic wait_done(input int c0, output int cyc);
    cyc = c0;
    while (!bus.done && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic chk_res(input string nm, input logic [15:0] er, input logic eb,
                         input logic eo, input logic en, input logic ez);
    chk({nm, "_result"},   32'(bus.result),   32'(er));
    chk({nm, "_borrow"},   32'(bus.borrow),   32'(eb));
    chk({nm, "_overflow"}, 32'(bus.overflow), 32'(eo));
    chk({nm, "_negative"}, 32'(bus.negative), 32'(en));
    chk({nm, "_zero"},     32'(bus.zero),     32'(ez));
  endtask

  task automatic do_op(input string nm, input logic [15:0] ai, input logic [15:0] bi,
                       input logic [15:0] er, input logic eb, input logic eo,
                       input logic en, input logic ez);
    int cyc;
    start_op(ai, bi);
    wait_done(0, cyc);
    chk({nm, "_latency"}, 32'(cyc), 32'd16);
    chk_res(nm, er, eb, eo, en, ez);
  endtask

  initial begin
    int cyc;
    int seen;
    n_vec = 0; n_err = 0; chk_on = 1'b0;
    reset = 1'b1; bus.start = 1'b0; bus.a = 16'h0; bus.b = 16'h0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk_on = 1'b1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk_res("rst", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

    do_op("one_minus_one", 16'h0001, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    do_op("inv_add",       16'h1081, 16'h0001, 16'h1080, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op("minus_neg5",    16'h0001, 16'hFFFB, 16'h0006, 1'b1, 1'b0, 1'b0, 1'b0);
    do_op("ovf_min",       16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0);
    do_op("ovf_max",       16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1, 1'b1, 1'b0);

    // Start pulse with new operands mid-operation must be dropped.
    start_op(16'hA211, 16'h0730);
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (i == 5) begin
        bus.start = 1'b1; bus.a = 16'h1111; bus.b = 16'h2222;
      end else begin
        bus.start = 1'b0;
      end
      chk("ignore_busy", 32'(bus.busy), 32'd1);
    end
    wait_done(8, cyc);
    chk("ignore_latency", 32'(cyc), 32'd16);
    chk_res("ignore", 16'h9AE1, 1'b0, 1'b0, 1'b1, 1'b0);

    // Back-to-back: start held high through the end of the first op.
    start_op(16'h0005, 16'h0003);
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (i == 10) begin
        bus.start = 1'b1; bus.a = 16'h0000; bus.b = 16'h0001;
      end
    end
    wait_done(10, cyc);
    chk("b2b_first_latency", 32'(cyc), 32'd16);
    chk_res("b2b_first", 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    bus.start = 1'b0; bus.a = 16'h5555;
    wait_done(1, cyc);
    chk("b2b_gap", 32'(cyc), 32'd17);
    chk_res("b2b_second", 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0);

    // Reset in the middle of RUN aborts without a done pulse.
    start_op(16'h4321, 16'h0123);
    repeat (7) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk_res("abort", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.done) seen++;
    end
    chk("abort_no_done", 32'(seen), 32'd0);
    do_op("after_abort", 16'h1234, 16'h0234, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1 chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sub16_serial.md
Name: sub16_serial

Overview:
Multi-cycle, bit-serial 16-bit two's-complement subtractor. It computes result = a - b, one bit per clock, LSB first, through a single full-subtractor cell. It is the inverse-operation companion to the combinational 16-bit adder and shares its operand format. It serves as the low-area SUB path for the ALU/sequencer, with a start/busy/done handshake.

Parameters:
WIDTH, 16, operand and result width in bits.
CNT_W, 5, bit-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  rising-edge clock, the only clock.
reset  input  1  synchronous, active-high reset.
start  input  1  request; sampled only when not busy.
a  input  WIDTH  minuend, two's complement; sampled with start.
b  input  WIDTH  subtrahend, two's complement; sampled with start.
busy  output  1  high while an operation is in progress.
done  output  1  one-cycle pulse; result and flags are valid from this cycle on.
result  output  WIDTH  a - b modulo 2^WIDTH; held until the next done.
borrow  output  1  final borrow out; 1 when a < b as unsigned values.
overflow  output  1  signed overflow: (a[15] != b[15]) && (result[15] != a[15]).
negative  output  1  result[15].
zero  output  1  result == 0.

Behaviour:
- Interface: one clock `clk`; reset `reset` is synchronous and active-high.
- Reset: state=IDLE; busy=0, done=0, result=0, borrow=0, overflow=0, negative=0, zero=0.
- Reset while RUN aborts the operation and forces the same values. No done is issued.
- FSM states: IDLE, RUN, DONE.
- IDLE: if start=1 at edge E0:
  - latch a and b into shift registers;
  - clear borrow_r=0 and cnt=0;
  - go to RUN;
  - busy=1 from E0.
- RUN: each edge, using LSB operand bits ai, bi:
  - d = ai ^ bi ^ borrow_r
  - borrow_r <= (~ai & bi) | (~(ai ^ bi) & borrow_r)
  - shift d into the result shift register MSB-ward (right shift)
  - shift both operand registers right by 1
  - cnt++
- After the 16th RUN edge (E16), go to DONE:
  - result register holds the full difference;
  - borrow, overflow, negative and zero update at E16 from the final values;
  - overflow uses the latched operand sign bits, captured at E0.
- Output timing:
  - busy=1 from the E0 edge through the E16 edge;
  - busy=0 and done=1 for exactly one cycle after E16;
  - latency from the start edge to done is 16 clocks.
- DONE: always returns to IDLE at the next edge. If start=1 in the DONE cycle, it is accepted (back-to-back) and goes directly to RUN.
- start while busy (RUN) is ignored. Operand changes during RUN have no effect.
- result and flags stay stable outside E16. No partial result appears on the result port; partial bits live only in the internal shift register.
- Wrap-around: the result is modulo 2^16. Example: 0x0000 - 0x0001 = 0xFFFF with borrow=1.

Decomposition:
- Shared constants include:
  - WIDTH default;
  - FSM state encodings: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
- Natural sub-module: full_subtractor, a 1-bit cell.
  - Inputs: x, y, bin.
  - Outputs: d, bout.
  - Built from the existing xor/and/or/not gate primitives.
- Top level holds: FSM, bit counter, operand shift registers, result shift register, flag logic.

Test Plan:
- 0x0001 - 0x0001: done 16 cycles after start; result=0x0000, zero=1, borrow=0, overflow=0, negative=0.
- 0x1081 - 0x0001 (inverse of 0x0001 + 0x1080): result=0x1080. Then 0x0001 - 0xFFFB (1 - (-5)): result=0x0006, borrow=1, overflow=0.
- 0x8000 - 0x0001: result=0x7FFF, overflow=1, negative=0. Then 0x7FFF - 0xFFFF: result=0x8000, overflow=1, negative=1.
- Start pulse with new operands at cycle 5 of a busy operation: ignored. The first result (0xA211 - 0x0730 = 0x9AE1) appears unchanged; busy stays high throughout.
- Back-to-back: start held high across the DONE cycle with 0x0000 - 0x0001. A second done arrives exactly 17 cycles after the first; result=0xFFFF, borrow=1.
- Reset asserted at RUN cycle 8: all outputs are 0 the next cycle and no done pulse appears. A new start afterwards completes normally.
